// File: rtl/fg_pkg.sv
// fg_pkg: shared state encoding and default bitwidths for the function-generator sequencer
package fg_pkg;
  localparam int COUNTER_BW  = 32;
  localparam int WAVEFORM_BW = 16;
  localparam int PRESCALE_BW = 16;
  localparam int BURST_BW    = 16;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/fg_prescaler.sv
// fg_prescaler: free-running 0..max_i counter with a terminal-count strobe
// Ports: clk_i/rst_i clock and sync reset; clr_i holds the count at 0; en_i advances it;
//        max_i terminal value; strb_o high while enabled and count == max_i.
module fg_prescaler #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic         strb_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    strb_o = en_i && cnt_q == max_i;
    cnt_d  = clr_i || strb_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fg_sequencer.sv
// fg_sequencer: timebase, burst/stop control and double-buffered shape config for the waveform datapath
// Ports: clk_i/rst_i clock and sync reset; start_i/stop_i run control; prescale_i/burst_i latched at start;
//        cfg_* shadow write handshake; strb_data_valid_o + counterValue_o timebase to the generator;
//        counter_o/ON_counter_o/k_rise_o/k_fall_o/amplitude_o active shape; busy_o in RUN; done_o end-of-run pulse.
module fg_sequencer
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH  = COUNTER_BW,
  parameter int WAVEFORM_BITWIDTH = WAVEFORM_BW,
  parameter int PRESCALE_BITWIDTH = PRESCALE_BW,
  parameter int BURST_BITWIDTH    = BURST_BW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic [PRESCALE_BITWIDTH-1:0] prescale_i,
  input  logic [BURST_BITWIDTH-1:0]    burst_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [COUNTER_BITWIDTH-1:0]  cfg_period_i,
  input  logic [COUNTER_BITWIDTH-1:0]  cfg_on_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] cfg_amplitude_i,
  output logic                         strb_data_valid_o,
  output logic [COUNTER_BITWIDTH-1:0]  counterValue_o,
  output logic [COUNTER_BITWIDTH-1:0]  counter_o,
  output logic [COUNTER_BITWIDTH-1:0]  ON_counter_o,
  output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0] amplitude_o,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int CW = 2 * COUNTER_BITWIDTH + 3 * WAVEFORM_BITWIDTH;
  state_t                       state_q, state_d;
  logic [CW-1:0]                shadow_q, shadow_d, active_q, active_d;
  logic [COUNTER_BITWIDTH-1:0]  cnt_q, cnt_d;
  logic [PRESCALE_BITWIDTH-1:0] prescale_q, prescale_d;
  logic [BURST_BITWIDTH-1:0]    burst_q, burst_d, left_q, left_d;
  logic                         pending_q, pending_d, cfg_ready_q, stop_pend_q, stop_pend_d, done_q;
  logic                         strb, cfg_fire, period_end, start_go, last, commit;

  fg_prescaler #(.W(PRESCALE_BITWIDTH)) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q == RUN),
    .max_i  (prescale_q),
    .strb_o (strb)
  );

  assign {counter_o, ON_counter_o, k_rise_o, k_fall_o, amplitude_o} = active_q;
  assign strb_data_valid_o = strb;
  assign counterValue_o    = cnt_q;
  assign cfg_ready_o       = cfg_ready_q;
  assign busy_o            = state_q == RUN;
  assign done_o            = done_q;

  always_comb begin
    cfg_fire    = cfg_valid_i && cfg_ready_q;
    start_go    = state_q == IDLE && start_i && !stop_i;
    period_end  = strb && cnt_q == counter_o;
    // a stop raised in the very cycle of a period end still ends the run there
    last        = period_end && (stop_pend_q || stop_i || (burst_q != '0 && left_q == BURST_BITWIDTH'(1)));
    // IDLE commits on the cycle after the write, which also covers the start cycle
    commit      = pending_q && (state_q == IDLE || period_end);
    pending_d   = cfg_fire || (pending_q && !commit);
    shadow_d    = cfg_fire ? {cfg_period_i, cfg_on_i, cfg_k_rise_i, cfg_k_fall_i, cfg_amplitude_i} : shadow_q;
    active_d    = commit ? shadow_q : active_q;
    cnt_d       = period_end || state_q == IDLE ? '0 : strb ? cnt_q + 1'b1 : cnt_q;
    prescale_d  = start_go ? prescale_i : prescale_q;
    burst_d     = start_go ? burst_i : burst_q;
    left_d      = start_go ? burst_i : period_end && burst_q != '0 ? left_q - 1'b1 : left_q;
    stop_pend_d = state_q == RUN && !last && (stop_pend_q || stop_i);
    state_d     = start_go ? RUN : last ? IDLE : state_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      prescale_q  <= '0;
      burst_q     <= '0;
      left_q      <= '0;
      pending_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      prescale_q  <= prescale_d;
      burst_q     <= burst_d;
      left_q      <= left_d;
      pending_q   <= pending_d;
      cfg_ready_q <= !pending_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= last;
    end
  end
endmodule
